// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin arbiter sharing one Wishbone slave between
// NUM_MASTERS masters. Ownership is per bus cycle: the granted master keeps
// the slave until it drops CYC, and one idle cycle separates owners.
// Optional stall timeout is compiled in with `define WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_WIDTH   = DATA_WIDTH/8,
  parameter int TIMEOUT     = 255
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  output logic [SEL_WIDTH-1:0]              s_sel_o,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  input  logic                              s_ack_i,
  output logic [NUM_MASTERS-1:0]            gnt_o,
  output logic                              busy_o
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  // ERR / WAIT_DROP only exist when the timeout is compiled in
  typedef enum logic [1:0] {S_IDLE, S_OWN, S_ERR, S_WAIT} state_t;

  state_t                 r_state, w_state_nxt;
  logic [IW-1:0]          r_idx;    // granted master index
  logic [IW-1:0]          r_last;   // last owner, round-robin pointer
  logic [NUM_MASTERS-1:0] r_gnt;
  logic [IW-1:0]          w_pick;
  logic                   w_any;
  logic                   w_cyc_g;
  logic                   w_stb_g;

  assign w_cyc_g = m_cyc_i[r_idx];
  assign w_stb_g = m_stb_i[r_idx] & w_cyc_g;
  assign gnt_o   = r_gnt;
  assign busy_o  = (r_state != S_IDLE);

  // first requester searching upward from r_last+1 with wrap-around
  always_comb begin : pick
    int k;
    k      = 0;
    w_pick = '0;
    w_any  = 1'b0;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      k = (int'(r_last) + off) % NUM_MASTERS;
      if (!w_any && m_cyc_i[k]) begin
        w_any  = 1'b1;
        w_pick = IW'(k);
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT+1);
  logic [CW-1:0] r_cnt;
  logic          w_stall;
  logic          w_tmo;

  assign w_stall = (r_state == S_OWN) && w_stb_g && !s_ack_i;
  // the stall that completes TIMEOUT stalled cycles sends us to ERR next
  assign w_tmo   = w_stall && (r_cnt == CW'(TIMEOUT-1));

  // stall counter: counts un-acked strobe cycles of the current owner
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                          r_cnt <= '0;
    else if (r_state != S_OWN || s_ack_i || !w_cyc_g)   r_cnt <= '0;
    else if (w_stall)                                   r_cnt <= r_cnt + 1'b1;
  end
`endif

  // state register plus grant / pointer bookkeeping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_last  <= IW'(NUM_MASTERS-1);
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_any) begin
        r_idx <= w_pick;
        r_gnt <= NUM_MASTERS'(1) << w_pick;
      end else if (r_state != S_IDLE && w_state_nxt == S_IDLE) begin
        r_last <= r_idx;
        r_gnt  <= '0;
      end
    end
  end

  // next-state: grant on any CYC, release when the owner drops CYC
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_any) w_state_nxt = S_OWN;
      S_OWN: begin
        if (!w_cyc_g) w_state_nxt = S_IDLE;
`ifdef WB_ARB_TIMEOUT_EN
        else if (w_tmo) w_state_nxt = S_ERR;
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      S_ERR:  w_state_nxt = S_WAIT;
      S_WAIT: if (!w_cyc_g) w_state_nxt = S_IDLE;
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // outputs: slave side follows the owner combinationally, quiet otherwise
  always_comb begin
    m_dat_o = s_dat_i;
    m_ack_o = '0;
    m_err_o = '0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    case (r_state)
      S_OWN: begin
        s_cyc_o        = w_cyc_g;
        s_stb_o        = w_stb_g;
        s_we_o         = m_we_i[r_idx];
        s_adr_o        = m_adr_i[int'(r_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        s_dat_o        = m_dat_i[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH];
        s_sel_o        = m_sel_i[int'(r_idx)*SEL_WIDTH +: SEL_WIDTH];
        m_ack_o[r_idx] = s_ack_i & w_cyc_g;
      end
`ifdef WB_ARB_TIMEOUT_EN
      S_ERR: m_err_o[r_idx] = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (default build, two masters). A bus-level
// ownership model predicts every output each cycle; scenario checks pin the
// grant order, ack counts and cycle-exact timing.
module tb_wb_rr_arbiter;
  localparam int N = 2, AW = 32, DW = 32, SW = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic [N-1:0]  cyc = '0, stb = '0, we = '0;
  logic [N*AW-1:0] adr = '0;
  logic [N*DW-1:0] dat = '0;
  logic [N*SW-1:0] sel = '0;
  logic [DW-1:0] sdat = 32'h5A5A_5A5A;
  logic          sack = 1'b0;

  logic [DW-1:0] m_dat_o;
  logic [N-1:0]  m_ack_o, m_err_o, gnt_o;
  logic          s_cyc_o, s_stb_o, s_we_o, busy_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [SW-1:0] s_sel_o;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we),
    .m_adr_i(adr), .m_dat_i(dat), .m_sel_i(sel),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(sdat), .s_ack_i(sack),
    .gnt_o(gnt_o), .busy_o(busy_o)
  );

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Ownership model: who holds the bus, and who held it last.
  int owner = -1, last = N-1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      owner = -1; last = N-1;
    end else if (owner < 0) begin
      for (int off = 1; off <= N; off++)
        if (owner < 0 && cyc[(last+off)%N]) owner = (last+off)%N;
    end else if (!cyc[owner]) begin
      last = owner; owner = -1;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin : cmp
    logic eo;
    eo = (owner >= 0);
    chk("gnt",   gnt_o,   eo ? (64'd1 << owner) : 64'd0);
    chk("busy",  busy_o,  eo);
    chk("s_cyc", s_cyc_o, eo ? cyc[owner] : 1'b0);
    chk("s_stb", s_stb_o, eo ? (cyc[owner] & stb[owner]) : 1'b0);
    chk("s_we",  s_we_o,  eo ? we[owner] : 1'b0);
    chk("s_adr", s_adr_o, eo ? adr[owner*AW +: AW] : 32'd0);
    chk("s_dat", s_dat_o, eo ? dat[owner*DW +: DW] : 32'd0);
    chk("s_sel", s_sel_o, eo ? sel[owner*SW +: SW] : 4'd0);
    chk("m_ack", m_ack_o, eo ? ({63'd0, sack & cyc[owner]} << owner) : 64'd0);
    chk("m_err", m_err_o, 0);
    chk("m_dat", m_dat_o, sdat);
  end

  // grant order log and ack tallies
  int glog[$];
  int acks0 = 0, acks1 = 0;
  logic [N-1:0] pg = '0;
  always @(negedge clk) begin
    if (gnt_o != '0 && pg == '0) glog.push_back(gnt_o[1] ? 1 : 0);
    pg = gnt_o;
    acks0 += int'(m_ack_o[0]);
    acks1 += int'(m_ack_o[1]);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Scripted masters + slave. txN transactions of btN beats each; master m
  // may first raise CYC at cycle sdN; slave acks ack_dly cycles after STB.
  task automatic run(input int tx0, input int tx1, input int bt0, input int bt1,
                     input int sd0, input int ack_dly, input int budget);
    int txl[N], bt[N], bl[N], sd[N];
    int wt, n;
    logic [N-1:0] ncyc, nstb;
    logic nack;
    txl[0] = tx0; txl[1] = tx1; bt[0] = bt0; bt[1] = bt1;
    sd[0] = sd0; sd[1] = 0; bl[0] = 0; bl[1] = 0;
    wt = 0; n = 0;
    adr = {32'h2000_0040, 32'h1000_0020};
    dat = {32'hCAFE_0001, 32'h1234_5678};
    sel = {4'h3, 4'hC};
    we  = 2'b10;
    while ((txl[0] > 0 || txl[1] > 0 || cyc != '0) && n < budget) begin
      @(negedge clk);
      ncyc = cyc; nstb = stb; nack = 1'b0;
      for (int m = 0; m < N; m++) begin
        if (cyc[m] && m_ack_o[m]) begin
          bl[m]--;
          if (bl[m] == 0) begin ncyc[m] = 1'b0; nstb[m] = 1'b0; txl[m]--; end
        end else if (!cyc[m] && txl[m] > 0 && n >= sd[m]) begin
          ncyc[m] = 1'b1; nstb[m] = 1'b1; bl[m] = bt[m];
        end
      end
      if (s_stb_o && !sack) begin
        if (wt >= ack_dly) begin nack = 1'b1; wt = 0; end
        else wt++;
      end else wt = 0;
      @(posedge clk); #1;
      cyc = ncyc; stb = nstb; sack = nack;
      n++;
    end
    chk("run_budget", n < budget, 1);
    tick(); tick();
  endtask

  initial begin : stim
    int s, a0, a1;
    // reset state
    tick(); tick();
    chk("rst_gnt", gnt_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_scyc", s_cyc_o, 0);
    chk("rst_mdat", m_dat_o, 32'h5A5A_5A5A);
    rst = 1'b0;
    tick();

    // 1: master 0 single write, slave acks 2 cycles after STB
    cyc = 2'b01; stb = 2'b01; we = 2'b01;
    adr[31:0] = 32'h100; dat[31:0] = 32'hDEAD_BEEF; sel[3:0] = 4'hF;
    #1 chk("w_lat_scyc", s_cyc_o, 0);
    tick();
    chk("w_gnt", gnt_o, 2'b01);
    chk("w_scyc", s_cyc_o, 1);
    chk("w_adr", s_adr_o, 32'h100);
    chk("w_dat", s_dat_o, 32'hDEAD_BEEF);
    chk("w_sel", s_sel_o, 4'hF);
    chk("w_we", s_we_o, 1);
    tick(); tick();
    sack = 1'b1;
    #1 chk("w_ack", m_ack_o, 2'b01);
    tick();
    sack = 1'b0; cyc = '0; stb = '0;
    #1 chk("w_drop_scyc", s_cyc_o, 0);
    chk("w_drop_gnt", gnt_o, 2'b01);
    tick();
    chk("w_rel_gnt", gnt_o, 2'b00);
    chk("w_rel_busy", busy_o, 0);
    tick();

    // 2: simultaneous request right after reset -> 0 then 1
    rst = 1'b1; tick(); rst = 1'b0; tick();
    s = glog.size();
    run(1, 1, 1, 1, 0, 1, 100);
    chk("sim_n", glog.size() - s, 2);
    if (glog.size() >= s + 2) begin
      chk("sim_first", glog[s], 0);
      chk("sim_second", glog[s+1], 1);
    end

    // 3: continuous requesters alternate over 8 transactions
    s = glog.size(); a0 = acks0; a1 = acks1;
    run(4, 4, 1, 1, 0, 0, 300);
    chk("alt_n", glog.size() - s, 8);
    for (int i = 0; i < 8; i++)
      if (s + i < glog.size()) chk("alt_order", glog[s+i], i % 2);
    chk("alt_acks0", acks0 - a0, 4);
    chk("alt_acks1", acks1 - a1, 4);

    // 4: master 1 bursts 4 beats; master 0 waits for its release
    s = glog.size(); a0 = acks0; a1 = acks1;
    run(1, 1, 1, 4, 2, 1, 300);
    chk("burst_n", glog.size() - s, 2);
    if (glog.size() >= s + 2) begin
      chk("burst_first", glog[s], 1);
      chk("burst_second", glog[s+1], 0);
    end
    chk("burst_acks1", acks1 - a1, 4);
    chk("burst_acks0", acks0 - a0, 1);

    // 5: aborted cycle, late slave ack is not forwarded
    a0 = acks0;
    cyc = 2'b01; stb = 2'b01;
    tick(); tick();
    cyc = '0; stb = '0; sack = 1'b1;
    #1 chk("abort_ack", m_ack_o, 0);
    chk("abort_scyc", s_cyc_o, 0);
    tick();
    sack = 1'b0;
    tick();
    chk("abort_acks0", acks0 - a0, 0);

    // 6: asynchronous reset mid-transfer
    cyc = 2'b10; stb = 2'b10;
    tick(); tick();
    chk("mid_stb", s_stb_o, 1);
    #1 rst = 1'b1;
    #1 chk("mid_scyc", s_cyc_o, 0);
    chk("mid_sstb", s_stb_o, 0);
    chk("mid_gnt", gnt_o, 0);
    chk("mid_busy", busy_o, 0);
    tick();
    rst = 1'b0; cyc = 2'b11; stb = 2'b11;
    tick();
    chk("post_rst_gnt", gnt_o, 2'b01);
    cyc = '0; stb = '0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
